// File: rtl/weight_tile_sequencer_if.sv
// Handshake and bus bundle between the weight tile sequencer, its instruction
// source, the weight memory read port, the weight FIFO and the tile consumer.
interface weight_tile_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
);
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] row_stride_i;
    logic [CNT_W-1:0]  tiles_n_i;
    logic [CNT_W-1:0]  tiles_k_i;
    logic              fifo_full_i;
    logic              next_weight_tile_i;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              fifo_wr_en_o;
    logic              fifo_wr_last_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, base_addr_i, row_stride_i, tiles_n_i, tiles_k_i,
        output fifo_full_i, next_weight_tile_i,
        input  rd_en_o, rd_addr_o, fifo_wr_en_o, fifo_wr_last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, base_addr_i, row_stride_i, tiles_n_i, tiles_k_i,
        input  fifo_full_i, next_weight_tile_i,
        output rd_en_o, rd_addr_o, fifo_wr_en_o, fifo_wr_last_o, busy_o, done_o
    );
endinterface

// File: rtl/weight_tile_sequencer.sv
// Streams MUL_SIZE-row weight tiles (n outer, k inner) from weight memory into
// the weight FIFO, throttled by FIFO backpressure and a two-tile credit.
module weight_tile_sequencer #(
    parameter int MUL_SIZE = 16,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    weight_tile_sequencer_if.slave bus
);

    localparam int ROW_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CREDIT, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ROW_W-1:0]  row_q;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  tiles_n_q;
    logic [CNT_W-1:0]  tiles_k_q;
    logic [1:0]        credit_q;
    logic [1:0]        credit_d;
    logic              wr_en_q;
    logic              wr_last_q;
    logic              done_q;

    logic rd_en;
    logic row_last;
    logic k_last;
    logic n_last;
    logic tile_issue;

    // A returned credit is dropped when both buffers are already free.
    function automatic logic [1:0] credit_next(input logic [1:0] c,
                                               input logic       ret,
                                               input logic       take);
        logic [1:0] r;
        r = c;
        if (ret && (c != 2'd2)) r = r + 2'd1;
        if (take)               r = r - 2'd1;
        return r;
    endfunction

    assign rd_en      = (state_q == ISSUE) && !bus.fifo_full_i && (credit_q != 2'd0);
    assign row_last   = (row_q == ROW_W'(MUL_SIZE - 1));
    assign k_last     = (k_q == tiles_k_q - CNT_W'(1));
    assign n_last     = (n_q == tiles_n_q - CNT_W'(1));
    assign tile_issue = rd_en && row_last;
    assign credit_d   = credit_next(credit_q, bus.next_weight_tile_i, tile_issue);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            row_q     <= '0;
            k_q       <= '0;
            n_q       <= '0;
            tiles_n_q <= '0;
            tiles_k_q <= '0;
            credit_q  <= 2'd2;
            wr_en_q   <= 1'b0;
            wr_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Memory returns data one cycle after the read, so the FIFO write trails rd_en.
            wr_en_q   <= rd_en;
            wr_last_q <= tile_issue && k_last;
            done_q    <= 1'b0;
            credit_q  <= credit_d;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        tiles_n_q <= bus.tiles_n_i;
                        tiles_k_q <= bus.tiles_k_i;
                        stride_q  <= bus.row_stride_i;
                        addr_q    <= bus.base_addr_i;
                        row_q     <= '0;
                        k_q       <= '0;
                        n_q       <= '0;
                        credit_q  <= 2'd2;
                        if ((bus.tiles_n_i == '0) || (bus.tiles_k_i == '0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        addr_q <= addr_q + stride_q;
                        row_q  <= row_last ? '0 : row_q + ROW_W'(1);
                    end
                    if (tile_issue) begin
                        if (k_last) begin
                            k_q <= '0;
                            n_q <= n_q + CNT_W'(1);
                        end else begin
                            k_q <= k_q + CNT_W'(1);
                        end
                        if (k_last && n_last) begin
                            state_q <= DRAIN;
                        end else if (credit_d == 2'd0) begin
                            state_q <= WAIT_CREDIT;
                        end
                    end
                end
                WAIT_CREDIT: begin
                    if (bus.next_weight_tile_i) state_q <= ISSUE;
                end
                DRAIN: begin
                    if (credit_q == 2'd2) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_en_o        = rd_en;
    assign bus.rd_addr_o      = addr_q;
    assign bus.fifo_wr_en_o   = wr_en_q;
    assign bus.fifo_wr_last_o = wr_last_q;
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.done_o         = done_q;

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Directed and randomized bench for weight_tile_sequencer against a
// row-index/credit reference model.
module tb_weight_tile_sequencer;

    localparam int MUL = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    weight_tile_sequencer_if #(.ADDR_W(16), .CNT_W(8)) bus ();

    weight_tile_sequencer #(.MUL_SIZE(MUL), .ADDR_W(16), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: a run is a flat list of rows, index i -> address and last flag
    bit          m_active;
    int          m_idx, m_total, m_credit, m_tn, m_tk;
    logic [15:0] m_base, m_stride;
    bit          m_prev_rd, m_prev_last, m_exp_done;
    int          ret_delay;
    int          due[$];

    int obs_reads, obs_last, obs_dones, first_rd, last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] addr_of(input int i);
        logic [31:0] a;
        a = 32'(m_base) + 32'(i) * 32'(m_stride);
        return a[15:0];
    endfunction

    function automatic bit last_of(input int i);
        return ((i % MUL) == MUL - 1) && (((i / MUL) % m_tk) == m_tk - 1);
    endfunction

    task automatic tick(input logic st, input logic fl, input logic nx);
        bit exp_rd, tdone, ret, nd;
        bus.start_i            = st;
        bus.fifo_full_i        = fl;
        bus.next_weight_tile_i = nx;
        #1;
        exp_rd = m_active && (m_idx < m_total) && !fl && (m_credit > 0);
        chk("rd_en_o", 32'(bus.rd_en_o), 32'(exp_rd));
        if (exp_rd) chk("rd_addr_o", 32'(bus.rd_addr_o), 32'(addr_of(m_idx)));
        chk("fifo_wr_en_o", 32'(bus.fifo_wr_en_o), 32'(m_prev_rd));
        chk("fifo_wr_last_o", 32'(bus.fifo_wr_last_o), 32'(m_prev_last));
        chk("done_o", 32'(bus.done_o), 32'(m_exp_done));
        chk("busy_o", 32'(bus.busy_o), 32'(m_active));
        if (bus.rd_en_o === 1'b1) begin
            if (obs_reads == 0) first_rd = cyc;
            last_rd = cyc;
            obs_reads++;
        end
        if ((bus.fifo_wr_en_o === 1'b1) && (bus.fifo_wr_last_o === 1'b1)) obs_last++;
        if (bus.done_o === 1'b1) obs_dones++;

        tdone       = exp_rd && ((m_idx % MUL) == MUL - 1);
        m_prev_last = exp_rd && last_of(m_idx);
        m_prev_rd   = exp_rd;
        nd          = 1'b0;
        if (!m_active) begin
            if (st) begin
                if ((bus.tiles_n_i == 8'd0) || (bus.tiles_k_i == 8'd0)) begin
                    nd = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_base   = bus.base_addr_i;
                    m_stride = bus.row_stride_i;
                    m_tn     = int'(bus.tiles_n_i);
                    m_tk     = int'(bus.tiles_k_i);
                    m_total  = m_tn * m_tk * MUL;
                    m_idx    = 0;
                    m_credit = 2;
                end
            end
        end else begin
            if ((m_idx == m_total) && (m_credit == 2)) begin
                nd       = 1'b1;
                m_active = 1'b0;
            end
            ret      = nx && (m_credit < 2);
            m_credit = m_credit + int'(ret) - int'(tdone);
            if (exp_rd) m_idx++;
            if (tdone && (ret_delay > 0)) due.push_back(cyc + ret_delay);
        end
        m_exp_done = nd;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int max_cyc, input int full_mode, input int ret_mode, input bit busy_start);
        for (int i = 0; i < max_cyc; i++) begin
            logic fl, nx, st;
            fl = 1'b0;
            nx = 1'b0;
            st = 1'b0;
            if (full_mode == 1)      fl = ((cyc % 2) == 1);
            else if (full_mode == 2) fl = ($urandom_range(0, 2) == 0);
            if (ret_mode == 1) begin
                if ((due.size() > 0) && (due[0] <= cyc)) begin
                    nx = 1'b1;
                    void'(due.pop_front());
                end
            end else if (ret_mode == 2) begin
                nx = ($urandom_range(0, 2) == 0);
            end
            if (busy_start && m_active && ($urandom_range(0, 7) == 0)) begin
                st               = 1'b1;
                bus.base_addr_i  = 16'($urandom);
                bus.row_stride_i = 16'($urandom);
                bus.tiles_n_i    = 8'($urandom_range(0, 3));
                bus.tiles_k_i    = 8'($urandom_range(0, 3));
            end
            tick(st, fl, nx);
            if (!m_active && !m_exp_done && !m_prev_rd) break;
        end
    endtask

    task automatic start_cmd(input logic [15:0] base, input logic [15:0] stride,
                             input logic [7:0] tn, input logic [7:0] tk);
        bus.base_addr_i  = base;
        bus.row_stride_i = stride;
        bus.tiles_n_i    = tn;
        bus.tiles_k_i    = tk;
        obs_reads = 0;
        obs_last  = 0;
        obs_dones = 0;
        first_rd  = 0;
        last_rd   = 0;
        due.delete();
        tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.start_i            = 1'b0;
        bus.fifo_full_i        = 1'b0;
        bus.next_weight_tile_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst rd_en_o", 32'(bus.rd_en_o), 32'd0);
        chk("rst rd_addr_o", 32'(bus.rd_addr_o), 32'd0);
        chk("rst fifo_wr_en_o", 32'(bus.fifo_wr_en_o), 32'd0);
        chk("rst fifo_wr_last_o", 32'(bus.fifo_wr_last_o), 32'd0);
        chk("rst busy_o", 32'(bus.busy_o), 32'd0);
        chk("rst done_o", 32'(bus.done_o), 32'd0);
        chk("rst credit_q", 32'(dut.credit_q), 32'd2);
        m_active    = 1'b0;
        m_idx       = 0;
        m_total     = 0;
        m_credit    = 2;
        m_prev_rd   = 1'b0;
        m_prev_last = 1'b0;
        m_exp_done  = 1'b0;
        due.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        rst                    = 1'b1;
        bus.start_i            = 1'b0;
        bus.base_addr_i        = '0;
        bus.row_stride_i       = '0;
        bus.tiles_n_i          = '0;
        bus.tiles_k_i          = '0;
        bus.fifo_full_i        = 1'b0;
        bus.next_weight_tile_i = 1'b0;
        m_tk                   = 1;
        ret_delay              = 0;
        @(negedge clk);
        do_reset();

        // basic 1x1, consumer retires 5 cycles after issue
        ret_delay = 5;
        start_cmd(16'h0100, 16'd1, 8'd1, 8'd1);
        run(60, 0, 1, 1'b0);
        chk("basic reads", 32'(obs_reads), 32'd16);
        chk("basic last", 32'(obs_last), 32'd1);
        chk("basic done", 32'(obs_dones), 32'd1);

        // credit stall with no retirement
        ret_delay = 0;
        start_cmd(16'h0200, 16'd1, 8'd1, 8'd3);
        run(45, 0, 0, 1'b0);
        chk("stall reads", 32'(obs_reads), 32'd32);
        chk("stall busy", 32'(bus.busy_o), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        run(25, 0, 0, 1'b0);
        chk("stall released reads", 32'(obs_reads), 32'd48);
        chk("stall last", 32'(obs_last), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        run(10, 0, 0, 1'b0);
        chk("stall done", 32'(obs_dones), 32'd1);

        // backpressure toggling every other cycle
        ret_delay = 5;
        start_cmd(16'h0300, 16'd1, 8'd1, 8'd1);
        run(80, 1, 1, 1'b0);
        chk("bp reads", 32'(obs_reads), 32'd16);
        chk("bp done", 32'(obs_dones), 32'd1);

        // retirement coincides with tile completion at credit 1: no bubble
        ret_delay = 16;
        start_cmd(16'h0400, 16'd2, 8'd1, 8'd3);
        run(120, 0, 1, 1'b0);
        chk("simul reads", 32'(obs_reads), 32'd48);
        chk("simul span", 32'(last_rd - first_rd + 1), 32'd48);
        chk("simul done", 32'(obs_dones), 32'd1);

        // zero K tiles
        ret_delay = 0;
        start_cmd(16'h0500, 16'd1, 8'd2, 8'd0);
        run(5, 0, 0, 1'b0);
        chk("zero reads", 32'(obs_reads), 32'd0);
        chk("zero done", 32'(obs_dones), 32'd1);

        // start pulses while busy are ignored
        ret_delay = 5;
        start_cmd(16'h0600, 16'd2, 8'd2, 8'd1);
        run(200, 0, 1, 1'b1);
        chk("busy-start reads", 32'(obs_reads), 32'd32);
        chk("busy-start done", 32'(obs_dones), 32'd1);

        // address wrap
        start_cmd(16'hFFF8, 16'd1, 8'd1, 8'd1);
        run(60, 0, 1, 1'b0);
        chk("wrap reads", 32'(obs_reads), 32'd16);

        // reset mid-tile, then a fresh instruction
        ret_delay = 0;
        start_cmd(16'h2000, 16'd3, 8'd2, 8'd2);
        run(7, 0, 0, 1'b0);
        chk("pre-reset reads", 32'(obs_reads), 32'd7);
        do_reset();
        tick(1'b0, 1'b0, 1'b0);
        ret_delay = 5;
        start_cmd(16'h3000, 16'd1, 8'd1, 8'd1);
        run(60, 0, 1, 1'b0);
        chk("post-reset reads", 32'(obs_reads), 32'd16);
        chk("post-reset done", 32'(obs_dones), 32'd1);

        // randomized configurations, backpressure and retirement
        ret_delay = 0;
        for (int r = 0; r < 6; r++) begin
            logic [7:0] tn, tk;
            tn = 8'($urandom_range(1, 3));
            tk = 8'($urandom_range(1, 3));
            start_cmd(16'($urandom), 16'($urandom_range(1, 65535)), tn, tk);
            run(3000, 2, 2, 1'b1);
            chk("rand reads", 32'(obs_reads), 32'(int'(tn) * int'(tk) * MUL));
            chk("rand last", 32'(obs_last), 32'(tn));
            chk("rand done", 32'(obs_dones), 32'd1);
            chk("rand idle", 32'(bus.busy_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
